wb_seq_loader: RTL

- Wishbone master sitting directly upstream of the four-engine Wishbone slave wrapper.
- Takes a job command plus a 32-bit valid/ready word stream. Issues the slave's write sequence: optional 12 weight words, then 2×N_PAIRS input-data words.
- Then performs the result read at address 0xA0 and presents the 32-bit {outb,outa} result on a valid/ready output port.
- Replaces firmware bit-banging of the slave's address map.

---
 rtl/wb_seq_loader_pkg.sv | 21 ++
 rtl/wb_seq_addr_gen.sv | 21 ++
 rtl/wb_seq_loader.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/wb_seq_loader_pkg.sv
// Shared types and slave address map for wb_seq_loader and its address generator.
package wb_seq_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WGT  = 3'd1,
    S_DAT  = 3'd2,
    S_RD   = 3'd3,
    S_RES  = 3'd4
  } state_e;

  localparam logic [7:0] W_BASE      = 8'h51;
  localparam logic [7:0] D_LO        = 8'hC0;
  localparam logic [7:0] D_HI        = 8'hC8;
  localparam logic [7:0] RES_ADDR    = 8'hA0;
  localparam int         N_WGT_WORDS = 12;

  // Word counter holds up to 16 (2 * max N_PAIRS) without wrapping.
  localparam int CNT_W = 5;

endpackage

// File: rtl/wb_seq_addr_gen.sv
// Combinational slave address from the current phase and word counter.
module wb_seq_addr_gen
  import wb_seq_loader_pkg::*;
(
  input  state_e             phase_i,
  input  logic [CNT_W-1:0]   cnt_i,
  output logic [7:0]         addr_o
);

  always_comb begin
    addr_o = 8'h00;
    case (phase_i)
      S_WGT:   addr_o = W_BASE + {3'b000, cnt_i};
      // Even words fill the low half of entry cnt>>1, odd words the high half.
      S_DAT:   addr_o = (cnt_i[0] ? D_HI : D_LO) | {5'b00000, cnt_i[3:1]};
      S_RD:    addr_o = RES_ADDR;
      default: addr_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/wb_seq_loader.sv
// Wishbone master: writes optional weights plus input data to the slave, then
// reads the result at 0xA0. Define WB_ACK_TIMEOUT_EN to abort a write on missing ack.
module wb_seq_loader
  import wb_seq_loader_pkg::*;
#(
  parameter int N_PAIRS = 8,
  parameter int RD_HOLD = 2,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        load_w,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        wb_cyc,
  output logic        wb_str,
  output logic        wb_we,
  output logic [7:0]  wb_addr,
  output logic [31:0] wb_dout,
  input  logic [31:0] wb_din,
  input  logic        wb_ack,
  output state_e      dbg_state
);

`ifdef WB_ACK_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int               HOLD_W    = $clog2(RD_HOLD);
  localparam int               TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WGT  = CNT_W'(N_WGT_WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_DAT  = CNT_W'(2 * N_PAIRS - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(RD_HOLD - 1);
  localparam logic [TMO_W-1:0] LAST_TMO  = TMO_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [31:0]         dout_q, dout_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [31:0]         res_q, res_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                tmo_hit;
  logic [7:0]          gen_addr;

  wb_seq_addr_gen u_addr_gen (
    .phase_i (state_q),
    .cnt_i   (cnt_q),
    .addr_o  (gen_addr)
  );

  assign tmo_hit = TMO_EN && (tmo_q == LAST_TMO);

  // Streams (s_*, res_*) transfer a word on a clock edge where valid && ready;
  // valid never depends on ready, and the producer holds data stable until then.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    dout_d  = dout_q;
    hold_d  = hold_q;
    res_d   = res_q;
    done_d  = 1'b0;
    err_d   = err_q;
    tmo_d   = tmo_q;
    s_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = load_w ? S_WGT : S_DAT;
          cnt_d   = '0;
          pend_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_WGT, S_DAT: begin
        s_ready = !pend_q;
        if (!pend_q) begin
          if (s_valid) begin
            dout_d = s_data;
            pend_d = 1'b1;
            tmo_d  = '0;
          end
        end else if (wb_ack) begin
          pend_d = 1'b0;
          if (state_q == S_WGT && cnt_q == LAST_WGT) begin
            state_d = S_DAT;
            cnt_d   = '0;
          end else if (state_q == S_DAT && cnt_q == LAST_DAT) begin
            state_d = S_RD;
            cnt_d   = '0;
            hold_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (tmo_hit) begin
          pend_d  = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (tmo_q != LAST_TMO) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RD: begin
        // Slave data_out is registered, so only the last hold cycle is valid.
        if (hold_q == LAST_HOLD) begin
          res_d   = wb_din;
          state_d = S_RES;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RES: begin
        if (res_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      dout_q  <= '0;
      hold_q  <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dout_q  <= dout_d;
      hold_q  <= hold_d;
      res_q   <= res_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign wb_cyc    = pend_q || (state_q == S_RD);
  assign wb_str    = wb_cyc;
  assign wb_we     = pend_q;
  assign wb_addr   = wb_cyc ? gen_addr : 8'h00;
  assign wb_dout   = dout_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = TMO_EN && err_q;
  assign res_valid = (state_q == S_RES);
  assign res_data  = res_q;
  assign dbg_state = state_q;

endmodule
